// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiters: FSM encoding and
// the index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } arb_state_e;

  // Width of an index over n items, never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin search: first asserted request starting just after rr_last,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_priority_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_last,
  output logic               found,
  output logic [ID_W-1:0]    sel_id
);

  logic [ID_W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        sel_id = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// One word per grant: latch at grant, write and ack once the FIFO has room.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ   = 4,
  parameter int unsigned  DATA_SIZE = 8,
  localparam int unsigned ID_W      = clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  input  logic                         fifo_full,
  output logic                         fifo_write,
  output logic [DATA_SIZE-1:0]         fifo_write_data,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id
);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      rr_last_q, rr_last_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 found;
  logic [ID_W-1:0]      sel_id;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_sel (
    .req     (req),
    .rr_last (rr_last_q),
    .found   (found),
    .sel_id  (sel_id)
  );

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    fifo_write = 1'b0;
    ack        = '0;
    unique case (state_q)
      ST_IDLE: begin
        // No new grant while full, so a granted word is never stranded behind one.
        if (found && !fifo_full) begin
          state_d    = ST_WRITE;
          rr_last_d  = sel_id;
          grant_id_d = sel_id;
          data_d     = req_data[sel_id*DATA_SIZE +: DATA_SIZE];
        end
      end
      ST_WRITE: begin
        if (!fifo_full) begin
          fifo_write      = 1'b1;
          ack[grant_id_q] = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
    end
  end

  assign busy            = (state_q == ST_WRITE);
  assign grant_id        = grant_id_q;
  assign fifo_write_data = data_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios then random producers and
// FIFO reads, checked every cycle against a transaction-level reference.
module tb_fifo_write_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 2;
  localparam int          DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic          fifo_full;
  logic          fifo_write;
  logic [DW-1:0] fifo_write_data;
  logic          busy;
  logic [IW-1:0] grant_id;

  fifo_write_arbiter #(
    .NUM_REQ   (N),
    .DATA_SIZE (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_data        (req_data),
    .ack             (ack),
    .fifo_full       (fifo_full),
    .fifo_write      (fifo_write),
    .fifo_write_data (fifo_write_data),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: a pending-grant record plus the round-robin pointer.
  bit            m_busy;
  int            m_gid;
  int            m_rr;
  logic [DW-1:0] m_data;

  bit            pend[N];
  logic [DW-1:0] pdata[N];
  int            cnt;
  bit            force_full, rd_rand, rd_once, auto_prod, reraise;
  int            n_wr;
  int            n_ack[N];
  int            wr_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_gid  = 0;
    m_rr   = N - 1;
    m_data = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]                = pend[i];
      req_data[i*DW +: DW]  = pdata[i];
    end
    fifo_full = force_full || (cnt >= DEPTH);
  endtask

  task automatic cycle();
    bit           ew, rd, gnt;
    logic [N-1:0] ea;
    int           g;
    @(negedge clk);
    ew = m_busy && !fifo_full && !reset;
    ea = '0;
    if (ew) ea[m_gid] = 1'b1;
    chk("fifo_write", fifo_write, ew);
    chk("ack", ack, ea);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("fifo_write_data", fifo_write_data, m_data);
    if (fifo_write === 1'b1) begin
      n_wr++;
      wr_log.push_back(int'(grant_id));
    end
    for (int i = 0; i < N; i++) if (ack[i] === 1'b1) n_ack[i]++;

    gnt = 1'b0;
    g   = 0;
    if (!reset && !m_busy && !fifo_full) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (!gnt && pend[c]) begin
          gnt = 1'b1;
          g   = c;
        end
      end
    end
    rd = (cnt > 0) && (rd_once || (rd_rand && ($urandom % 2 == 0)));

    @(posedge clk);
    #1;
    if (reset) model_reset();
    else if (ew) m_busy = 1'b0;
    else if (gnt) begin
      m_busy = 1'b1;
      m_gid  = g;
      m_rr   = g;
      m_data = pdata[g];
    end
    cnt = cnt + (ew ? 1 : 0) - (rd ? 1 : 0);
    for (int i = 0; i < N; i++) begin
      if (ea[i]) begin
        if (reraise) begin
          pend[i]  = 1'b1;
          pdata[i] = DW'($urandom);
        end else pend[i] = 1'b0;
      end else if (auto_prod) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i]  = 1'b1;
          pdata[i] = DW'($urandom);
        end else if (gnt && g == i && ($urandom % 4 == 0)) begin
          pend[i] = 1'b0;
        end
      end
    end
    drive();
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_write"}, fifo_write, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gid"}, grant_id, 0);
    chk({tag, "_data"}, fifo_write_data, 0);
    model_reset();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    force_full = 0; rd_rand = 0; rd_once = 0; auto_prod = 0; reraise = 0;
    cnt = 0; n_wr = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pdata[i] = '0; n_ack[i] = 0;
    end
    model_reset();
    drive();
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);

    // Reset while a grant to producer 2 is stalled on a full FIFO.
    pend[2] = 1'b1; pdata[2] = 8'h3C; drive();
    cycle();
    force_full = 1'b1; drive();
    cycle();
    chk("t1_busy", busy, 1);
    chk("t1_gid", grant_id, 2);
    async_reset_check("t1_rst");

    // All four requesting, re-raised after each ack.
    force_full = 1'b0; reraise = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pdata[i] = DW'($urandom);
    end
    drive();
    wr_log.delete();
    n_wr = 0;
    repeat (16) cycle();
    chk("t1_first_grant", (wr_log.size() > 0) ? wr_log[0] : -1, 0);
    chk("t3_writes", n_wr, 8);
    for (int i = 0; i < wr_log.size(); i++) chk("t3_order", wr_log[i], i % N);
    reraise = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    cycle();

    // Single request from producer 2.
    pend[2] = 1'b1; pdata[2] = 8'hA5; drive();
    cycle();
    chk("t2_write", fifo_write, 1);
    chk("t2_data", fifo_write_data, 8'hA5);
    chk("t2_ack", ack, 4'b0100);
    chk("t2_gid", grant_id, 2);
    cycle();
    chk("t2_write_off", fifo_write, 0);

    // Full raised while in WRITE.
    pend[3] = 1'b1; pdata[3] = 8'h5A; drive();
    cycle();
    force_full = 1'b1; drive();
    n_wr = 0;
    repeat (3) begin
      cycle();
      chk("t5_write", fifo_write, 0);
      chk("t5_ack", ack, 0);
      chk("t5_busy", busy, 1);
    end
    force_full = 1'b0; drive();
    repeat (3) cycle();
    chk("t5_once", n_wr, 1);

    // Producer 3 withdraws its request right after the grant.
    pend[3] = 1'b1; pdata[3] = 8'hC3; drive();
    cycle();
    pend[3] = 1'b0; drive();
    n_wr = 0; n_ack[3] = 0;
    repeat (3) cycle();
    chk("t6_writes", n_wr, 1);
    chk("t6_ack3", n_ack[3], 1);

    // FIFO one slot short of full with two requesters.
    cnt = DEPTH - 1;
    pend[0] = 1'b1; pdata[0] = 8'h11;
    pend[1] = 1'b1; pdata[1] = 8'h22;
    drive();
    cycle();
    cycle();
    repeat (3) begin
      cycle();
      chk("t4_nogrant", busy, 0);
    end
    rd_once = 1'b1;
    cycle();
    rd_once = 1'b0;
    chk("t4_nogrant_rd", busy, 0);
    cycle();
    chk("t4_gid", grant_id, 1);
    chk("t4_write", fifo_write, 1);
    chk("t4_ack", ack, 4'b0010);
    cycle();

    // Random producers, reads and forced-full bursts, with one async reset.
    rd_rand = 1'b1; auto_prod = 1'b1;
    for (int n = 0; n < 600; n++) begin
      force_full = ($urandom % 8 == 0);
      drive();
      cycle();
      if (n == 300) async_reset_check("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
